or_word_unit: RTL and testbench

//   Bitwise-OR word unit for the ALU logic group.

---
 rtl/alu_logic_pkg.sv | 20 ++
 rtl/or_bit.sv | 10 +
 rtl/or_word_unit.sv | 86 ++++++++
 tb/tb_or_word_unit.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/alu_logic_pkg.sv
// Shared definitions for the ALU logic group (and/or/xor word units).
package alu_logic_pkg;

   // Default operand/result width of the logic-group word units
   localparam int ALU_WORD_W = 20;

   // Widest word the shared popcount helper accepts
   localparam int POP_MAX_W = 64;

   // Number of set bits in a word. Narrower words are zero-extended by the caller.
   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned cnt;
      cnt = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         cnt = cnt + {31'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/or_bit.sv
// One-bit OR cell; replicated across the word by or_word_unit.
module or_bit (
   input  logic a,
   input  logic b,
   output logic o
);

   assign o = a | b;

endmodule

// File: rtl/or_word_unit.sv
// Registered bitwise-OR word unit with zero / all-ones / parity / popcount flags.
// Flags are derived from the next result and registered alongside it, so they
// always describe the word currently on o. WIDTH must be at least 2.
module or_word_unit
   import alu_logic_pkg::*;
#(
   parameter  int WIDTH = ALU_WORD_W,
   localparam int PCW   = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] o,
   output logic             zero,
   output logic             ones,
   output logic             parity,
   output logic [PCW-1:0]   popcnt
);

   logic [WIDTH-1:0] o_next;
   logic             zero_next;
   logic             ones_next;
   logic             parity_next;
   logic [PCW-1:0]   popcnt_next;

   logic             out_valid_reg;
   logic [WIDTH-1:0] o_reg;
   logic             zero_reg;
   logic             ones_reg;
   logic             parity_reg;
   logic [PCW-1:0]   popcnt_reg;

   // Combinational OR word built from one cell per bit
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_or_bits
         or_bit u_or_bit (
            .a (a[gi]),
            .b (b[gi]),
            .o (o_next[gi])
         );
      end
   endgenerate

   // Flag reduction on the next result; accumulator is sized to hold 0..WIDTH
   always_comb begin
      zero_next   = ~|o_next;
      ones_next   = &o_next;
      parity_next = ^o_next;
      popcnt_next = '0;
      for (int i = 0; i < WIDTH; i++) begin
         popcnt_next = popcnt_next + PCW'(o_next[i]);
      end
   end

   // Result/flag register: load on in_valid, hold otherwise; valid is a one-cycle strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         o_reg         <= '0;
         zero_reg      <= 1'b1;
         ones_reg      <= 1'b0;
         parity_reg    <= 1'b0;
         popcnt_reg    <= '0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            o_reg      <= o_next;
            zero_reg   <= zero_next;
            ones_reg   <= ones_next;
            parity_reg <= parity_next;
            popcnt_reg <= popcnt_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign o         = o_reg;
   assign zero      = zero_reg;
   assign ones      = ones_reg;
   assign parity    = parity_reg;
   assign popcnt    = popcnt_reg;

endmodule

// File: tb/tb_or_word_unit.sv
// Directed and seeded-random bench for or_word_unit (WIDTH = 20).
module tb_or_word_unit;

   localparam int W   = 20;
   localparam int PCW = $clog2(W + 1);

   logic           clk;
   logic           rst;
   logic           in_valid;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           out_valid;
   logic [W-1:0]   o;
   logic           zero;
   logic           ones;
   logic           parity;
   logic [PCW-1:0] popcnt;

   int n_cmp  = 0;
   int n_fail = 0;

   or_word_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .o         (o),
      .zero      (zero),
      .ones      (ones),
      .parity    (parity),
      .popcnt    (popcnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle before sampling
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; a = 20'hFFFFF; b = 20'h00000;
      tick();
      tick();
      n_cmp++; if (o !== 20'h00000) begin n_fail++; $display("FAIL reset_o got=%h exp=00000", o); end
      n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got=%b exp=1", zero); end
      n_cmp++; if (ones !== 1'b0) begin n_fail++; $display("FAIL reset_ones got=%b exp=0", ones); end
      n_cmp++; if (popcnt !== 5'd0) begin n_fail++; $display("FAIL reset_popcnt got=%0d exp=0", popcnt); end
      n_cmp++; if (parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got=%b exp=0", parity); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      $display("reset: o=%h zero=%b ones=%b pop=%0d par=%b valid=%b", o, zero, ones, popcnt, parity, out_valid);
   endtask

   task automatic test_complementary();
      rst = 1'b0; in_valid = 1'b1; a = 20'hF0F0F; b = 20'h0F0F0;
      tick();
      n_cmp++; if (o !== 20'hFFFFF) begin n_fail++; $display("FAIL comp_o got=%h exp=fffff", o); end
      n_cmp++; if (ones !== 1'b1) begin n_fail++; $display("FAIL comp_ones got=%b exp=1", ones); end
      n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL comp_zero got=%b exp=0", zero); end
      n_cmp++; if (popcnt !== 5'd20) begin n_fail++; $display("FAIL comp_popcnt got=%0d exp=20", popcnt); end
      n_cmp++; if (parity !== 1'b0) begin n_fail++; $display("FAIL comp_parity got=%b exp=0", parity); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL comp_valid got=%b exp=1", out_valid); end
      $display("complementary: a=f0f0f b=0f0f0 o=%h pop=%0d", o, popcnt);
   endtask

   task automatic test_zero_operands();
      in_valid = 1'b1; a = 20'h00000; b = 20'h00000;
      tick();
      n_cmp++; if (o !== 20'h00000) begin n_fail++; $display("FAIL zero_o got=%h exp=00000", o); end
      n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL zero_flag got=%b exp=1", zero); end
      n_cmp++; if (popcnt !== 5'd0) begin n_fail++; $display("FAIL zero_popcnt got=%0d exp=0", popcnt); end
      n_cmp++; if (ones !== 1'b0) begin n_fail++; $display("FAIL zero_ones got=%b exp=0", ones); end
      $display("zero operands: o=%h zero=%b pop=%0d", o, zero, popcnt);
      a = 20'h12345; b = 20'h00001;
      tick();
      n_cmp++; if (o !== 20'h12345) begin n_fail++; $display("FAIL odd_o got=%h exp=12345", o); end
      n_cmp++; if (popcnt !== 5'd7) begin n_fail++; $display("FAIL odd_popcnt got=%0d exp=7", popcnt); end
      n_cmp++; if (parity !== 1'b1) begin n_fail++; $display("FAIL odd_parity got=%b exp=1", parity); end
      n_cmp++; if (zero !== 1'b0) begin n_fail++; $display("FAIL odd_zero got=%b exp=0", zero); end
      $display("odd word: a=12345 b=00001 o=%h pop=%0d par=%b", o, popcnt, parity);
   endtask

   task automatic test_hold();
      in_valid = 1'b1; a = 20'h80000; b = 20'h00001;
      tick();
      n_cmp++; if (o !== 20'h80001) begin n_fail++; $display("FAIL hold_load_o got=%h exp=80001", o); end
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_load_valid got=%b exp=1", out_valid); end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         a = 20'($urandom());
         b = 20'($urandom());
         tick();
         n_cmp++; if (o !== 20'h80001) begin n_fail++; $display("FAIL hold_o[%0d] got=%h exp=80001", k, o); end
         n_cmp++; if (popcnt !== 5'd2) begin n_fail++; $display("FAIL hold_popcnt[%0d] got=%0d exp=2", k, popcnt); end
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d] got=%b exp=0", k, out_valid); end
         $display("hold cycle %0d: a=%h b=%h o=%h pop=%0d valid=%b", k, a, b, o, popcnt, out_valid);
      end
   endtask

   task automatic test_reset_midstream();
      in_valid = 1'b1; a = 20'h00011; b = 20'h00100;
      tick();
      n_cmp++; if (o !== 20'h00111) begin n_fail++; $display("FAIL mid_pre_o got=%h exp=00111", o); end
      rst = 1'b1; a = 20'hAAAAA; b = 20'h55555;
      tick();
      n_cmp++; if (o !== 20'h00000) begin n_fail++; $display("FAIL mid_rst_o got=%h exp=00000", o); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", out_valid); end
      n_cmp++; if (zero !== 1'b1) begin n_fail++; $display("FAIL mid_rst_zero got=%b exp=1", zero); end
      rst = 1'b0; in_valid = 1'b0;
      tick();
      n_cmp++; if (o !== 20'h00000) begin n_fail++; $display("FAIL mid_drop_o got=%h exp=00000", o); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_drop_valid got=%b exp=0", out_valid); end
      $display("reset mid-stream: o=%h valid=%b", o, out_valid);
   endtask

   task automatic test_back_to_back_random();
      logic [W-1:0] exp_o;
      int unsigned  exp_pop;
      void'($urandom(10531));
      in_valid = 1'b1;
      for (int k = 0; k < 16; k++) begin
         a = 20'($urandom());
         b = 20'($urandom());
         exp_o   = a | b;
         exp_pop = $countones(exp_o);
         tick();
         n_cmp++; if (o !== exp_o) begin n_fail++; $display("FAIL rand_o[%0d] got=%h exp=%h", k, o, exp_o); end
         n_cmp++; if (popcnt !== PCW'(exp_pop)) begin n_fail++; $display("FAIL rand_popcnt[%0d] got=%0d exp=%0d", k, popcnt, exp_pop); end
         n_cmp++; if (parity !== exp_pop[0]) begin n_fail++; $display("FAIL rand_parity[%0d] got=%b exp=%b", k, parity, exp_pop[0]); end
         n_cmp++; if (zero !== (exp_o == '0)) begin n_fail++; $display("FAIL rand_zero[%0d] got=%b", k, zero); end
         n_cmp++; if (ones !== (exp_o == '1)) begin n_fail++; $display("FAIL rand_ones[%0d] got=%b", k, ones); end
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid[%0d] got=%b exp=1", k, out_valid); end
         $display("random %0d: a=%h b=%h o=%h pop=%0d par=%b", k, a, b, o, popcnt, parity);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
      test_reset();
      test_complementary();
      test_zero_operands();
      test_hold();
      test_reset_midstream();
      test_back_to_back_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
